// File: rtl/csa_mp_ctrl.sv
// rtl/csa_mp_ctrl.sv - multi-precision add/subtract sequencer over one 8-bit carry-select adder
// Optional subtract path enabled by defining CSA_MP_SUB_EN.

module csa_8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] s_o,
  output logic       cout_o
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  // Upper nibble is precomputed for both carries; the lower nibble's carry selects.
  assign lo  = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0000, cin_i};
  assign hi0 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
  assign hi1 = hi0 + 5'd1;

  assign s_o[3:0]          = lo[3:0];
  assign {cout_o, s_o[7:4]} = lo[4] ? hi1 : hi0;
endmodule

module csa_mp_ctrl #(
  parameter int BYTES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [8*BYTES-1:0] a_i,
  input  logic [8*BYTES-1:0] b_i,
  input  logic               cin_i,
`ifdef CSA_MP_SUB_EN
  input  logic               sub_i,
`endif
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [8*BYTES-1:0] sum_o,
  output logic               cout_o,
  output logic               ovf_o,
  output logic               busy_o
);
  localparam int IW = $clog2(BYTES);
  localparam int W  = 8 * BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
`ifdef CSA_MP_SUB_EN
  logic            sub_q, sub_d;
`endif

  logic [7:0] a_byte;
  logic [7:0] b_eff;
  logic [7:0] byte_sum;
  logic       byte_cout;

  assign a_byte = a_q[{idx_q, 3'b000} +: 8];
`ifdef CSA_MP_SUB_EN
  assign b_eff  = b_q[{idx_q, 3'b000} +: 8] ^ {8{sub_q}};
`else
  assign b_eff  = b_q[{idx_q, 3'b000} +: 8];
`endif

  csa_8 u_csa (
    .a_i    (a_byte),
    .b_i    (b_eff),
    .cin_i  (carry_q),
    .s_o    (byte_sum),
    .cout_o (byte_cout)
  );

  assign in_ready_o  = (state_q == IDLE) & ~rst_i;
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef CSA_MP_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          a_d     = a_i;
          b_d     = b_i;
          idx_d   = '0;
`ifdef CSA_MP_SUB_EN
          sub_d   = sub_i;
          carry_d = sub_i ? 1'b1 : cin_i;
`else
          carry_d = cin_i;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 3'b000} +: 8] = byte_sum;
        carry_d = byte_cout;
        if (idx_q == IW'(BYTES - 1)) begin
          cout_d  = byte_cout;
          // Overflow: operands agree in sign but the result sign differs.
          ovf_d   = (a_byte[7] == b_eff[7]) && (byte_sum[7] != a_byte[7]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef CSA_MP_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef CSA_MP_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end
endmodule
